// File: rtl/stripe_tx_sequencer.sv
// Transmit sequencer ahead of the byte striper: frames packets (STP/SDP ... END/EDB),
// fills idle time with IDL and inserts lane-aligned SKP ordered sets.
module stripe_tx_sequencer #(
    parameter int unsigned LANES        = 4,
    parameter int unsigned BITS         = 8,
    parameter int unsigned SKP_INTERVAL = 64
) (
    input  logic                       clk,
    input  logic                       reset_l,
    input  logic [BITS-1:0]            in_d,
    input  logic                       in_valid,
    input  logic                       in_sop,
    input  logic                       in_eop,
    input  logic                       in_type,
    input  logic                       in_abort,
    output logic                       in_ready,
    output logic [BITS-1:0]            d,
    output logic                       dk,
    output logic [$clog2(LANES)-1:0]   lane_idx,
    output logic                       skp_active
);

    localparam int unsigned LW = $clog2(LANES);
    localparam int unsigned CW = $clog2(SKP_INTERVAL);
    localparam int unsigned OW = $clog2(4 * LANES);

    localparam logic [LW-1:0] LaneLast  = LW'(LANES - 1);
    localparam logic [LW-1:0] LanePen   = LW'(LANES - 2);
    localparam logic [CW-1:0] CntMax    = CW'(SKP_INTERVAL - 1);
    localparam logic [CW-1:0] CntPreMax = CW'(SKP_INTERVAL - 2);
    localparam logic [OW-1:0] OsLast    = OW'(4 * LANES - 1);
    localparam logic [OW-1:0] OsComEnd  = OW'(LANES);

    localparam logic [BITS-1:0] SymStp = BITS'(8'hFB);
    localparam logic [BITS-1:0] SymSdp = BITS'(8'h5C);
    localparam logic [BITS-1:0] SymEnd = BITS'(8'hFD);
    localparam logic [BITS-1:0] SymEdb = BITS'(8'hFE);
    localparam logic [BITS-1:0] SymCom = BITS'(8'hBC);
    localparam logic [BITS-1:0] SymSkp = BITS'(8'h1C);
    localparam logic [BITS-1:0] SymIdl = BITS'(8'h7C);

    typedef enum logic [2:0] {StIdle, StData, StTrail, StPad, StSkp} state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   lane_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic [OW-1:0]   os_q, os_d;
    logic            abort_q, abort_d;
    logic [BITS-1:0] d_q, d_d;
    logic            dk_q, dk_d;
    logic            act_q, act_d;
    logic            com_start;
    logic            aligned;
    logic            lands_last;

    // aligned: the next symbol lands on lane 0; lands_last: it lands on the last lane
    assign aligned    = (lane_q == LaneLast);
    assign lands_last = (lane_q == LanePen);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (aligned && pend_q) begin
                    state_d = StSkp;
                end else if (aligned && in_valid && in_sop) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (!in_valid) begin
                    state_d = StPad;
                end else if (in_eop) begin
                    state_d = StTrail;
                end
            end
            StTrail: state_d = lands_last ? StIdle : StPad;
            StPad:   if (lands_last) state_d = StIdle;
            StSkp:   if (os_q == OsLast) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        d_d       = SymIdl;
        dk_d      = 1'b0;
        act_d     = 1'b0;
        in_ready  = 1'b0;
        os_d      = os_q;
        abort_d   = abort_q;
        com_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (aligned && pend_q) begin
                    d_d       = SymCom;
                    act_d     = 1'b1;
                    os_d      = OW'(1);
                    com_start = 1'b1;
                end else if (aligned && in_valid && in_sop) begin
                    d_d = in_type ? SymSdp : SymStp;
                end
            end
            StData: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    d_d  = in_d;
                    dk_d = 1'b1;
                    if (in_eop) abort_d = in_abort;
                end else begin
                    d_d = SymEdb;
                end
            end
            StTrail: d_d = abort_q ? SymEdb : SymEnd;
            StPad:   d_d = SymIdl;
            StSkp: begin
                act_d = 1'b1;
                d_d   = (os_q < OsComEnd) ? SymCom : SymSkp;
                os_d  = os_q + OW'(1);
            end
            default: d_d = SymIdl;
        endcase
    end

    // SKP request timer saturates once the request is raised
    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        if (com_start) begin
            cnt_d  = '0;
            pend_d = 1'b0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CntPreMax) pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            lane_q  <= LaneLast;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            os_q    <= '0;
            abort_q <= 1'b0;
            d_q     <= SymIdl;
            dk_q    <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            lane_q  <= lane_q + LW'(1);
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            os_q    <= os_d;
            abort_q <= abort_d;
            d_q     <= d_d;
            dk_q    <= dk_d;
            act_q   <= act_d;
        end
    end

    assign d          = d_q;
    assign dk         = dk_q;
    assign lane_idx   = lane_q;
    assign skp_active = act_q;

endmodule
